// File: rtl/fetch_prefetch_buffer.sv
// Instruction-fetch front end: sequential requests to a variable-latency IMEM, returned words queued with their PCs.
// Optional FETCH_PERF_CNT_EN adds starvation and dropped-response counters.
module fetch_prefetch_buffer #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_7033
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instruction,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] starve_cycles,
  output logic [31:0] discard_count
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  typedef logic [CW:0]   sum_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      fifo_mem [DEPTH];
  ptr_t        rd_ptr;
  ptr_t        wr_ptr;
  cnt_t        occupancy;
  cnt_t        outstanding;
  cnt_t        discard_cnt;
  logic [31:0] fetch_pc;
  logic [31:0] tail_pc;
  logic [31:0] redirect_target;
  logic        req_fire;
  logic        rsp_take;
  logic        drop;
  logic        push;
  logic        pop;

  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  // Credits cover both buffered words and words still in flight, so a response always has a slot.
  assign mem_req_valid = reset && !redirect &&
                         ((sum_t'(occupancy) + sum_t'(outstanding)) < sum_t'(DEPTH));
  assign mem_req_addr  = fetch_pc;
  assign req_fire      = mem_req_valid && mem_req_ready;

  // Responses with nothing outstanding belong to requests issued before reset and are ignored.
  assign rsp_take = mem_rsp_valid && (outstanding != '0);
  assign drop     = rsp_take && (redirect || (discard_cnt != '0));
  assign push     = rsp_take && !drop;

  assign out_valid       = (occupancy != '0);
  assign pop             = out_valid && !stall && !redirect;
  assign out_pc          = out_valid ? fifo_mem[rd_ptr].pc    : 32'h0;
  assign out_instruction = out_valid ? fifo_mem[rd_ptr].instr : NOP_INSTR;

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      tail_pc     <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      occupancy   <= '0;
      outstanding <= '0;
      discard_cnt <= '0;
    end else begin
      outstanding <= outstanding + cnt_t'(req_fire) - cnt_t'(rsp_take);
      if (redirect) begin
        fetch_pc    <= redirect_target;
        tail_pc     <= redirect_target;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        occupancy   <= '0;
        // Everything still in flight after this cycle is stale; recomputed, never accumulated.
        discard_cnt <= outstanding - cnt_t'(rsp_take);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (drop) discard_cnt <= discard_cnt - cnt_t'(1);
        if (push) begin
          tail_pc <= tail_pc + 32'd4;
          wr_ptr  <= wr_ptr + ptr_t'(1);
        end
        if (pop) rd_ptr <= rd_ptr + ptr_t'(1);
        occupancy <= occupancy + cnt_t'(push) - cnt_t'(pop);
      end
    end
  end

  // NOTE: the storage array has no reset; occupancy gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{pc: tail_pc, instr: mem_rsp_data};
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cycles <= 32'h0;
      discard_count <= 32'h0;
    end else begin
      if (!out_valid && !redirect) starve_cycles <= starve_cycles + 32'd1;
      if (drop) discard_count <= discard_count + 32'd1;
    end
  end
`endif

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset)
    push |-> (occupancy < cnt_t'(DEPTH)));

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Self-checking bench for fetch_prefetch_buffer: bench-side memory with configurable latency,
// an epoch-based reference model compared every cycle, and directed scenarios with literal expectations.
module tb_fetch_prefetch_buffer;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_7033;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instruction;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] starve_cycles;
  logic [31:0] discard_count;
  int          perf_starve;
  int          perf_disc;
`endif

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  req_t        memq[$];
  ent_t        model_q[$];
  logic [31:0] model_pc;
  int          cyc;
  int          lat;
  int          epoch;
  int          vectors;
  int          miscompares;
  int          first_hs_cyc;
  int          first_ov_cyc;
  int          hs_count;
  int          stale_drops;

  fetch_prefetch_buffer #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instruction(out_instruction),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data)
`ifdef FETCH_PERF_CNT_EN
    ,
    .starve_cycles  (starve_cycles),
    .discard_count  (discard_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] addr);
    return {addr[15:0], 16'h0000} ^ 32'h1357_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare DUT outputs with the model, then advance the model by one clock.
  task automatic compare_cycle();
    logic exp_valid;
    logic exp_req;
    logic keep;
    req_t r;
    exp_valid = (model_q.size() != 0);
    check("out_valid", out_valid, exp_valid);
    if (exp_valid) begin
      check("out_pc", out_pc, model_q[0].pc);
      check("out_instruction", out_instruction, model_q[0].instr);
    end else begin
      check("out_instruction_bubble", out_instruction, NOP);
    end
    exp_req = !redirect && ((model_q.size() + memq.size()) < DEPTH);
    check("mem_req_valid", mem_req_valid, exp_req);
    if (exp_req) check("mem_req_addr", mem_req_addr, model_pc);
`ifdef FETCH_PERF_CNT_EN
    check("starve_cycles", starve_cycles, perf_starve);
    check("discard_count", discard_count, perf_disc);
    if (!exp_valid && !redirect) perf_starve++;
`endif
    if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;

    keep = 1'b0;
    if (mem_rsp_valid) begin
      r = memq.pop_front();
      keep = !redirect && (r.epoch == epoch);
      if (!keep) begin
        stale_drops++;
`ifdef FETCH_PERF_CNT_EN
        perf_disc++;
`endif
      end
    end
    if (redirect) begin
      model_q.delete();
      epoch++;
      model_pc = redirect_pc & 32'hFFFF_FFFC;
    end else if (exp_valid && !stall) begin
      void'(model_q.pop_front());
    end
    if (keep) model_q.push_back('{pc: r.addr, instr: instr_of(r.addr)});
    if (mem_req_valid && mem_req_ready) begin
      memq.push_back('{addr: mem_req_addr, due: cyc + lat, epoch: epoch});
      hs_count++;
      if (first_hs_cyc < 0) first_hs_cyc = cyc;
      if (!redirect) model_pc = model_pc + 32'd4;
    end
  endtask

  // Memory + compare process: inputs settle at negedge, memory drives at +1, compare at +2.
  initial begin
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      if (reset && memq.size() > 0 && memq[0].due <= cyc) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = instr_of(memq[0].addr);
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
      end
      #1;
      if (!reset) begin
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_pc", out_pc, 32'h0);
        check("reset_out_instruction", out_instruction, NOP);
        check("reset_mem_req_valid", mem_req_valid, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        check("reset_starve_cycles", starve_cycles, 32'h0);
        check("reset_discard_count", discard_count, 32'h0);
        perf_starve = 0;
        perf_disc   = 0;
`endif
        memq.delete();
        model_q.delete();
        model_pc     = 32'h0;
        epoch++;
        first_hs_cyc = -1;
        first_ov_cyc = -1;
        hs_count     = 0;
      end else begin
        compare_cycle();
      end
      cyc++;
    end
  end

  task automatic wait_valid(input string name, input int limit);
    int n;
    n = 0;
    @(negedge clk);
    #3;
    while (!out_valid && n < limit) begin
      @(negedge clk);
      #3;
      n++;
    end
    check(name, out_valid, 1'b1);
  endtask

  task automatic reset_pulse(input int new_lat);
    @(negedge clk);
    reset = 1'b0;
    lat   = new_lat;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int n;
    int mark;
    vectors = 0; miscompares = 0; cyc = 0; epoch = 0; stale_drops = 0;
    first_hs_cyc = -1; first_ov_cyc = -1; hs_count = 0; model_pc = 32'h0;
`ifdef FETCH_PERF_CNT_EN
    perf_starve = 0; perf_disc = 0;
`endif
    lat = 1; redirect = 1'b0; redirect_pc = 32'h0; stall = 1'b0; mem_req_ready = 1'b1;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);

    // Zero-wait streaming from reset.
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check("first_req_to_out_latency", first_ov_cyc - first_hs_cyc, 2);

    // Stall held for 10 cycles: buffer fills to DEPTH and requests stop.
    @(negedge clk);
    reset = 1'b0;
    stall = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    #3;
    check("stall_req_dropped", mem_req_valid, 1'b0);
    check("stall_head_pc", out_pc, 32'h0);
    check("stall_head_instr", out_instruction, 32'h1357_0013);
    check("stall_buffered_words", hs_count, DEPTH);
    @(negedge clk);
    stall = 1'b0;
    repeat (14) @(negedge clk);

    // Three-cycle memory, redirect with three requests in flight.
    reset_pulse(3);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (memq.size() != 3 && n < 30);
    check("three_outstanding", memq.size(), 3);
    mark        = stale_drops;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    @(negedge clk);
    redirect = 1'b0;
    wait_valid("redirect_100_valid", 30);
    check("redirect_first_pc", out_pc, 32'h0000_0100);
    check("stale_responses_dropped", stale_drops - mark, 3);
    wait_valid("redirect_104_valid", 30);
    check("redirect_second_pc", out_pc, 32'h0000_0104);
    repeat (6) @(negedge clk);

    // Unaligned redirect target.
    reset_pulse(1);
    repeat (6) @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0203;
    @(negedge clk);
    redirect = 1'b0;
    #3;
    check("aligned_req_valid", mem_req_valid, 1'b1);
    check("aligned_req_addr", mem_req_addr, 32'h0000_0200);
    wait_valid("aligned_out_valid", 20);
    check("aligned_out_pc", out_pc, 32'h0000_0200);

    // Redirect coinciding with a response and a would-be pop.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(memq.size() > 0 && memq[0].due <= cyc && model_q.size() > 0) && n < 30);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0300;
    #3;
    check("rsp_and_pop_overlap", {mem_rsp_valid, out_valid}, 2'b11);
    @(negedge clk);
    redirect = 1'b0;
    #3;
    check("flush_empty", out_valid, 1'b0);
    repeat (2) @(negedge clk);
    #3;
    check("flush_refill_valid", out_valid, 1'b1);
    check("flush_refill_pc", out_pc, 32'h0000_0300);

    // Back-to-back redirects: last target wins.
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0040;
    @(negedge clk);
    redirect_pc = 32'h0000_0080;
    @(negedge clk);
    redirect = 1'b0;
    wait_valid("b2b_valid", 20);
    check("b2b_pc", out_pc, 32'h0000_0080);
    repeat (4) @(negedge clk);

    // Reset asserted mid-stream takes effect immediately.
    reset = 1'b0;
    #1;
    check("async_out_valid", out_valid, 1'b0);
    check("async_out_pc", out_pc, 32'h0);
    check("async_out_instruction", out_instruction, NOP);
    check("async_mem_req_valid", mem_req_valid, 1'b0);
    lat = 2;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Two-cycle memory with back-pressure on requests and intermittent stalls.
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      mem_req_ready = (i % 4 != 1);
      stall         = (i % 3 == 2);
    end
    @(negedge clk);
    mem_req_ready = 1'b1;
    stall         = 1'b0;
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
